// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game playback path.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StGap,
    StDone
  } state_e;

  localparam int unsigned LED_COUNT = 10;
  localparam logic [31:0] DIV_FAST  = 32'd1250000;
  localparam logic [31:0] DIV_SLOW  = 32'd12500000;
  localparam int unsigned MAX_LEN   = 16;

  // Out-of-range LED indices decode to all-dark rather than aliasing.
  function automatic logic [LED_COUNT-1:0] led_decode(input logic [3:0] idx);
    logic [LED_COUNT-1:0] v;
    v = '0;
    if (idx < 4'(LED_COUNT)) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Single-cycle tick enable every div input clocks; clr restarts the period.
module tick_gen (
  input  logic        cin,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] div,
  output logic        tick
);

  logic [31:0] count_q;

  assign tick = (count_q == div - 32'd1);

  // Free-running period counter, restarted by clr or at the end of each period.
  always_ff @(posedge cin) begin
    if (rst || clr || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: rtl/seq_playback_ctrl.sv
// Plays the stored pattern onto the LEDs: ON phase per element, then a dark GAP.
module seq_playback_ctrl
  import game_pkg::*;
#(
  parameter logic [31:0] DIV_FAST  = game_pkg::DIV_FAST,
  parameter logic [31:0] DIV_SLOW  = game_pkg::DIV_SLOW,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned MAX_LEN   = game_pkg::MAX_LEN
) (
  input  logic                       cin,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       speed,
  input  logic [$clog2(MAX_LEN):0]   len,
  output logic [$clog2(MAX_LEN)-1:0] seq_addr,
  input  logic [3:0]                 seq_data,
  output logic [LED_COUNT-1:0]       led,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW  = $clog2(MAX_LEN);
  localparam int unsigned PhW = 8;

  state_e         state_q;
  logic [AW:0]    len_q;
  logic           speed_q;
  logic [PhW-1:0] ph_cnt_q;
  logic [31:0]    div;
  logic           tick;
  logic           ph_last;
  logic           phase_end;
  logic           tick_clr;

  assign div = speed_q ? DIV_FAST : DIV_SLOW;

  // Phase-end detect; the tick period restarts on every state entry and in idle states.
  always_comb begin
    ph_last = 1'b0;
    unique case (state_q)
      StOn:    ph_last = (ph_cnt_q == PhW'(ON_TICKS - 1));
      StGap:   ph_last = (ph_cnt_q == PhW'(GAP_TICKS - 1));
      default: ph_last = 1'b0;
    endcase
    phase_end = tick && ph_last;
    tick_clr  = !(state_q inside {StOn, StGap}) || phase_end || abort;
  end

  tick_gen u_tick_gen (
    .cin  (cin),
    .rst  (rst),
    .clr  (tick_clr),
    .div  (div),
    .tick (tick)
  );

  // Playback FSM with registered LED/busy/done outputs and the address counter.
  always_ff @(posedge cin) begin
    if (rst) begin
      state_q  <= StIdle;
      seq_addr <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      speed_q  <= 1'b0;
      ph_cnt_q <= '0;
    end else begin
      led  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ph_cnt_q <= '0;
            if (len == '0) begin
              state_q <= StDone;
            end else begin
              len_q    <= (len > (AW + 1)'(MAX_LEN)) ? (AW + 1)'(MAX_LEN) : len;
              speed_q  <= speed;
              seq_addr <= '0;
              state_q  <= StOn;
            end
          end
        end
        StOn: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            led  <= led_decode(seq_data);
            busy <= 1'b1;
            if (phase_end) begin
              ph_cnt_q <= '0;
              state_q  <= StGap;
            end else if (tick) begin
              ph_cnt_q <= ph_cnt_q + PhW'(1);
            end
          end
        end
        StGap: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            busy <= 1'b1;
            if (phase_end) begin
              ph_cnt_q <= '0;
              if ({1'b0, seq_addr} == len_q - 1'b1) begin
                state_q <= StDone;
              end else begin
                seq_addr <= seq_addr + AW'(1);
                state_q  <= StOn;
              end
            end else if (tick) begin
              ph_cnt_q <= ph_cnt_q + PhW'(1);
            end
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
